// File: rtl/hero_pkg.sv
// Shared types and constants for the H.E.R.O. game-flow controller and level renderers.
package hero_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY,
        ST_DYING,
        ST_NEXT,
        ST_GAME_OVER,
        ST_WIN
    } hero_state_e;

    localparam int LIVES_INIT_C = 3;
    localparam int BOMBS_INIT_C = 6;

    localparam int SCREEN_W = 635;
    localparam int SCREEN_H = 475;

    localparam logic [3:0] B_CNT_NONE  = 4'd0;
    localparam logic [3:0] B_CNT_BLAST = 4'd3;

endpackage

// File: rtl/hero_bomb_timer.sv
// Shared bomb resource: f_key edge detect, drop position latch, frame-stepped
// bomb phase counter and per-level bomb stock.
module hero_bomb_timer
    import hero_pkg::*;
#(
    parameter int BOMBS_INIT  = BOMBS_INIT_C,
    parameter int BOMB_FRAMES = 20
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       reload_i,
    input  logic       clear_i,
    input  logic       run_i,
    input  logic       frame_tick_i,
    input  logic       f_key_i,
    input  logic [9:0] char_x_i,
    input  logic [9:0] char_y_i,
    output logic [9:0] bomb_x_o,
    output logic [9:0] bomb_y_o,
    output logic [3:0] b_cnt_o,
    output logic [3:0] bombs_left_o
);
    localparam int FW = (BOMB_FRAMES > 1) ? $clog2(BOMB_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_RELOAD = FW'(BOMB_FRAMES - 1);

    logic          f_prev_q;
    logic [FW-1:0] frame_cnt_q;
    logic [3:0]    b_cnt_q;
    logic [3:0]    bombs_left_q;
    logic [9:0]    bomb_x_q;
    logic [9:0]    bomb_y_q;
    logic          fire_d;

    assign fire_d = run_i && f_key_i && !f_prev_q
                    && (b_cnt_q == B_CNT_NONE) && (bombs_left_q != 4'd0);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            f_prev_q     <= 1'b0;
            frame_cnt_q  <= '0;
            b_cnt_q      <= B_CNT_NONE;
            bombs_left_q <= 4'd0;
            bomb_x_q     <= 10'd0;
            bomb_y_q     <= 10'd0;
        end else begin
            f_prev_q <= f_key_i;
            if (reload_i) begin
                b_cnt_q      <= B_CNT_NONE;
                bombs_left_q <= 4'(BOMBS_INIT);
                frame_cnt_q  <= '0;
            end else if (clear_i) begin
                b_cnt_q     <= B_CNT_NONE;
                frame_cnt_q <= '0;
            end else if (fire_d) begin
                bomb_x_q     <= char_x_i;
                bomb_y_q     <= char_y_i;
                b_cnt_q      <= 4'd1;
                bombs_left_q <= bombs_left_q - 4'd1;
                frame_cnt_q  <= FRAME_RELOAD;
            end else if (run_i && frame_tick_i && (b_cnt_q != B_CNT_NONE)) begin
                // Terminal count steps the phase; blast wraps back to no bomb.
                if (frame_cnt_q == '0) begin
                    b_cnt_q     <= (b_cnt_q == B_CNT_BLAST) ? B_CNT_NONE : b_cnt_q + 4'd1;
                    frame_cnt_q <= FRAME_RELOAD;
                end else begin
                    frame_cnt_q <= frame_cnt_q - 1'b1;
                end
            end
        end
    end

    assign bomb_x_o     = bomb_x_q;
    assign bomb_y_o     = bomb_y_q;
    assign b_cnt_o      = b_cnt_q;
    assign bombs_left_o = bombs_left_q;

endmodule

// File: rtl/hero_level_ctrl.sv
// H.E.R.O. game-flow sequencer: level select/reload, lives, death, level
// completion, game-over and win. Bomb handling lives in hero_bomb_timer.
//
// state        | meaning
// IDLE         | waiting for start_key, renderers off
// LOAD         | level selected, enable low to reload bitmaps
// PLAY         | level running, bombs usable
// DYING        | death animation, counts frames before respawn
// NEXT         | one-clock level advance decision
// GAME_OVER    | out of lives, waits for start_key
// WIN          | last level cleared, waits for start_key
module hero_level_ctrl
    import hero_pkg::*;
#(
    parameter int NUM_LEVELS   = 4,
    parameter int LIVES_INIT   = LIVES_INIT_C,
    parameter int BOMBS_INIT   = BOMBS_INIT_C,
    parameter int LOAD_CYCLES  = 4,
    parameter int BOMB_FRAMES  = 20,
    parameter int DEATH_FRAMES = 60
) (
    input  logic                          CLOCK_50,
    input  logic                          rst_n,
    input  logic                          frame_tick,
    input  logic                          start_key,
    input  logic                          f_key,
    input  logic                          death_in,
    input  logic                          goal_in,
    input  logic [9:0]                    char_pos_x,
    input  logic [9:0]                    char_pos_y,
    output logic [NUM_LEVELS-1:0]         level_active,
    output logic                          enable,
    output logic [$clog2(NUM_LEVELS)-1:0] level_idx,
    output logic [9:0]                    bomb_pos_x,
    output logic [9:0]                    bomb_pos_y,
    output logic [3:0]                    b_cnt,
    output logic [3:0]                    bombs_left,
    output logic [2:0]                    lives,
    output logic                          game_over,
    output logic                          game_won
);
    localparam int IW = $clog2(NUM_LEVELS);
    localparam int LW = $clog2(LOAD_CYCLES + 1);
    localparam int DW = $clog2(DEATH_FRAMES + 1);
    localparam logic [IW-1:0] LAST_IDX    = IW'(NUM_LEVELS - 1);
    localparam logic [LW-1:0] LOAD_RELOAD = LW'(LOAD_CYCLES - 1);
    localparam logic [DW-1:0] DEATH_RELOAD = DW'(DEATH_FRAMES - 1);

    hero_state_e           state_q;
    logic [NUM_LEVELS-1:0] level_active_q;
    logic                  enable_q;
    logic                  game_over_q;
    logic                  game_won_q;
    logic [IW-1:0]         level_idx_q;
    logic [2:0]            lives_q;
    logic [LW-1:0]         load_cnt_q;
    logic [DW-1:0]         death_cnt_q;

    logic in_play_d;
    logic death_done_d;
    logic load_entry_d;
    logic bomb_clear_d;
    logic bomb_run_d;

    function automatic logic [NUM_LEVELS-1:0] onehot(input logic [IW-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    // Bomb reload must land on the same edge the FSM enters LOAD.
    assign in_play_d    = (state_q == ST_PLAY);
    assign death_done_d = (state_q == ST_DYING) && frame_tick && (death_cnt_q == '0);
    assign load_entry_d = ((state_q == ST_IDLE) && start_key)
                          || (death_done_d && (lives_q != 3'd0))
                          || ((state_q == ST_NEXT) && (level_idx_q != LAST_IDX));
    assign bomb_clear_d = in_play_d && death_in;
    assign bomb_run_d   = in_play_d && !death_in && !goal_in;

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            level_active_q <= '0;
            enable_q       <= 1'b0;
            game_over_q    <= 1'b0;
            game_won_q     <= 1'b0;
            level_idx_q    <= '0;
            lives_q        <= 3'(LIVES_INIT);
            load_cnt_q     <= '0;
            death_cnt_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    enable_q       <= 1'b0;
                    level_active_q <= '0;
                    if (start_key) begin
                        state_q        <= ST_LOAD;
                        level_idx_q    <= '0;
                        lives_q        <= 3'(LIVES_INIT);
                        level_active_q <= onehot('0);
                        load_cnt_q     <= LOAD_RELOAD;
                    end
                end
                ST_LOAD: begin
                    if (load_cnt_q == '0) begin
                        state_q  <= ST_PLAY;
                        enable_q <= 1'b1;
                    end else begin
                        load_cnt_q <= load_cnt_q - 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (death_in) begin
                        state_q     <= ST_DYING;
                        lives_q     <= (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
                        death_cnt_q <= DEATH_RELOAD;
                    end else if (goal_in) begin
                        state_q <= ST_NEXT;
                    end
                end
                ST_DYING: begin
                    if (frame_tick) begin
                        if (death_cnt_q == '0) begin
                            enable_q <= 1'b0;
                            if (lives_q == 3'd0) begin
                                state_q        <= ST_GAME_OVER;
                                level_active_q <= '0;
                                game_over_q    <= 1'b1;
                            end else begin
                                state_q    <= ST_LOAD;
                                load_cnt_q <= LOAD_RELOAD;
                            end
                        end else begin
                            death_cnt_q <= death_cnt_q - 1'b1;
                        end
                    end
                end
                ST_NEXT: begin
                    enable_q <= 1'b0;
                    if (level_idx_q == LAST_IDX) begin
                        state_q        <= ST_WIN;
                        level_active_q <= '0;
                        game_won_q     <= 1'b1;
                    end else begin
                        state_q        <= ST_LOAD;
                        level_idx_q    <= level_idx_q + 1'b1;
                        level_active_q <= onehot(level_idx_q + 1'b1);
                        load_cnt_q     <= LOAD_RELOAD;
                    end
                end
                ST_GAME_OVER, ST_WIN: begin
                    if (start_key) begin
                        state_q     <= ST_IDLE;
                        game_over_q <= 1'b0;
                        game_won_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    hero_bomb_timer #(
        .BOMBS_INIT  (BOMBS_INIT),
        .BOMB_FRAMES (BOMB_FRAMES)
    ) u_bomb (
        .clk_i        (CLOCK_50),
        .rst_n_i      (rst_n),
        .reload_i     (load_entry_d),
        .clear_i      (bomb_clear_d),
        .run_i        (bomb_run_d),
        .frame_tick_i (frame_tick),
        .f_key_i      (f_key),
        .char_x_i     (char_pos_x),
        .char_y_i     (char_pos_y),
        .bomb_x_o     (bomb_pos_x),
        .bomb_y_o     (bomb_pos_y),
        .b_cnt_o      (b_cnt),
        .bombs_left_o (bombs_left)
    );

    assign level_active = level_active_q;
    assign enable       = enable_q;
    assign level_idx    = level_idx_q;
    assign lives        = lives_q;
    assign game_over    = game_over_q;
    assign game_won     = game_won_q;

endmodule

// File: tb/tb_hero_level_ctrl.sv
// Bench for hero_level_ctrl: directed vector table, then random stimulus
// compared every cycle against a behavioural game model.
module tb_hero_level_ctrl;
    localparam int NUM_LEVELS   = 4;
    localparam int LIVES_INIT   = 3;
    localparam int BOMBS_INIT   = 6;
    localparam int LOAD_CYCLES  = 4;
    localparam int BOMB_FRAMES  = 20;
    localparam int DEATH_FRAMES = 60;

    localparam int P_IDLE = 0, P_LOAD = 1, P_PLAY = 2, P_DYING = 3, P_NEXT = 4, P_OVER = 5, P_WIN = 6;

    logic       CLOCK_50 = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start_key = 1'b0;
    logic       f_key = 1'b0;
    logic       death_in = 1'b0;
    logic       goal_in = 1'b0;
    logic [9:0] char_pos_x = 10'd0;
    logic [9:0] char_pos_y = 10'd0;
    logic [3:0] level_active;
    logic       enable;
    logic [1:0] level_idx;
    logic [9:0] bomb_pos_x, bomb_pos_y;
    logic [3:0] b_cnt, bombs_left;
    logic [2:0] lives;
    logic       game_over, game_won;

    int checks = 0;
    int failures = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    hero_level_ctrl #(
        .NUM_LEVELS(NUM_LEVELS), .LIVES_INIT(LIVES_INIT), .BOMBS_INIT(BOMBS_INIT),
        .LOAD_CYCLES(LOAD_CYCLES), .BOMB_FRAMES(BOMB_FRAMES), .DEATH_FRAMES(DEATH_FRAMES)
    ) dut (
        .CLOCK_50(CLOCK_50), .rst_n(rst_n), .frame_tick(frame_tick), .start_key(start_key),
        .f_key(f_key), .death_in(death_in), .goal_in(goal_in),
        .char_pos_x(char_pos_x), .char_pos_y(char_pos_y),
        .level_active(level_active), .enable(enable), .level_idx(level_idx),
        .bomb_pos_x(bomb_pos_x), .bomb_pos_y(bomb_pos_y), .b_cnt(b_cnt),
        .bombs_left(bombs_left), .lives(lives), .game_over(game_over), .game_won(game_won)
    );

    // Behavioural model: game phase plus elapsed-count bookkeeping.
    int m_ph, m_lvl, m_lives, m_bombs, m_bomb, m_bt, m_dt, m_ls, m_px, m_py;
    bit m_fprev;

    task automatic enter_load();
        m_ph = P_LOAD; m_ls = 1; m_bombs = BOMBS_INIT; m_bomb = 0; m_bt = 0;
    endtask

    task automatic model_step();
        bit fe;
        fe = f_key && !m_fprev;
        m_fprev = f_key;
        if (!rst_n) begin
            m_ph = P_IDLE; m_lvl = 0; m_lives = LIVES_INIT; m_bombs = 0; m_bomb = 0;
            m_bt = 0; m_dt = 0; m_ls = 0; m_px = 0; m_py = 0; m_fprev = 0;
            return;
        end
        case (m_ph)
            P_IDLE: if (start_key) begin m_lvl = 0; m_lives = LIVES_INIT; enter_load(); end
            P_LOAD: if (m_ls == LOAD_CYCLES) m_ph = P_PLAY; else m_ls++;
            P_PLAY: begin
                if (death_in) begin
                    m_ph = P_DYING; m_bomb = 0; m_dt = 0;
                    if (m_lives > 0) m_lives--;
                end else if (goal_in) begin
                    m_ph = P_NEXT;
                end else if (fe && m_bomb == 0 && m_bombs > 0) begin
                    m_px = int'(char_pos_x); m_py = int'(char_pos_y);
                    m_bomb = 1; m_bombs--; m_bt = 0;
                end else if (frame_tick && m_bomb != 0) begin
                    m_bt++;
                    if (m_bt == BOMB_FRAMES) begin m_bomb = (m_bomb + 1) % 4; m_bt = 0; end
                end
            end
            P_DYING: if (frame_tick) begin
                m_dt++;
                if (m_dt == DEATH_FRAMES) begin
                    if (m_lives == 0) m_ph = P_OVER; else enter_load();
                end
            end
            P_NEXT: if (m_lvl == NUM_LEVELS - 1) m_ph = P_WIN; else begin m_lvl++; enter_load(); end
            P_OVER, P_WIN: if (start_key) m_ph = P_IDLE;
            default: m_ph = P_IDLE;
        endcase
    endtask

    function automatic logic [63:0] model_out();
        bit vis, en;
        logic [3:0] act;
        vis = (m_ph == P_LOAD) || (m_ph == P_PLAY) || (m_ph == P_DYING) || (m_ph == P_NEXT);
        en  = (m_ph == P_PLAY) || (m_ph == P_DYING) || (m_ph == P_NEXT);
        act = vis ? 4'(1 << m_lvl) : 4'd0;
        return {24'd0, 2'(m_lvl), act, en, 4'(m_bomb), 4'(m_bombs), 3'(m_lives),
                (m_ph == P_OVER), (m_ph == P_WIN), 10'(m_px), 10'(m_py)};
    endfunction

    function automatic logic [63:0] dut_out();
        return {24'd0, level_idx, level_active, enable, b_cnt, bombs_left, lives,
                game_over, game_won, bomb_pos_x, bomb_pos_y};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (idx,act,en,bcnt,bombs,lives,over,won,px,py)", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLOCK_50);
        model_step();
        #1;
    endtask

    typedef struct {
        string name;
        bit r, st, f, d, g, t;
        int cx, cy, n;
        int idx, act, en, bc, bl, lv, ov, wn, px, py;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input string nm, input bit r, st, f, d, g, t, input int cx, cy, n,
                                input int idx, act, en, bc, bl, lv, ov, wn, px, py);
        vec_t v;
        v.name = nm; v.r = r; v.st = st; v.f = f; v.d = d; v.g = g; v.t = t;
        v.cx = cx; v.cy = cy; v.n = n; v.idx = idx; v.act = act; v.en = en; v.bc = bc;
        v.bl = bl; v.lv = lv; v.ov = ov; v.wn = wn; v.px = px; v.py = py;
        return v;
    endfunction

    function automatic logic [63:0] vec_exp(input vec_t v);
        return {24'd0, 2'(v.idx), 4'(v.act), 1'(v.en), 4'(v.bc), 4'(v.bl), 3'(v.lv),
                1'(v.ov), 1'(v.wn), 10'(v.px), 10'(v.py)};
    endfunction

    initial begin
        //                 name            r  st f  d  g  t  cx   cy  n   idx act en bc bl lv ov wn px   py
        tbl.push_back(mk("reset",          0, 0, 0, 0, 0, 0, 320, 200, 2, 0, 0, 0, 0, 0, 3, 0, 0, 0,   0));
        tbl.push_back(mk("start",          1, 1, 0, 0, 0, 0, 320, 200, 1, 0, 1, 0, 0, 6, 3, 0, 0, 0,   0));
        tbl.push_back(mk("load_hold",      1, 0, 0, 0, 0, 0, 320, 200, 3, 0, 1, 0, 0, 6, 3, 0, 0, 0,   0));
        tbl.push_back(mk("play",           1, 0, 0, 0, 0, 0, 320, 200, 1, 0, 1, 1, 0, 6, 3, 0, 0, 0,   0));
        tbl.push_back(mk("drop",           1, 0, 1, 0, 0, 0, 320, 200, 1, 0, 1, 1, 1, 5, 3, 0, 0, 320, 200));
        tbl.push_back(mk("fuse_19",        1, 0, 1, 0, 0, 1, 320, 200, 19, 0, 1, 1, 1, 5, 3, 0, 0, 320, 200));
        tbl.push_back(mk("f_low",          1, 0, 0, 0, 0, 0, 320, 200, 1, 0, 1, 1, 1, 5, 3, 0, 0, 320, 200));
        tbl.push_back(mk("refire_step2",   1, 0, 1, 0, 0, 1, 10,  10,  1, 0, 1, 1, 2, 5, 3, 0, 0, 320, 200));
        tbl.push_back(mk("step3",          1, 0, 0, 0, 0, 1, 320, 200, 20, 0, 1, 1, 3, 5, 3, 0, 0, 320, 200));
        tbl.push_back(mk("blast_19",       1, 0, 0, 0, 0, 1, 320, 200, 19, 0, 1, 1, 3, 5, 3, 0, 0, 320, 200));
        tbl.push_back(mk("blast_end",      1, 0, 0, 0, 0, 1, 320, 200, 1, 0, 1, 1, 0, 5, 3, 0, 0, 320, 200));
        tbl.push_back(mk("drop2",          1, 0, 1, 0, 0, 0, 100, 50,  1, 0, 1, 1, 1, 4, 3, 0, 0, 100, 50));
        tbl.push_back(mk("death_goal",     1, 0, 0, 1, 1, 1, 100, 50,  1, 0, 1, 1, 0, 4, 2, 0, 0, 100, 50));
        tbl.push_back(mk("dying_59",       1, 0, 0, 0, 0, 1, 100, 50,  59, 0, 1, 1, 0, 4, 2, 0, 0, 100, 50));
        tbl.push_back(mk("respawn",        1, 0, 0, 0, 0, 1, 100, 50,  1, 0, 1, 0, 0, 6, 2, 0, 0, 100, 50));
        tbl.push_back(mk("reload_play",    1, 0, 0, 0, 0, 0, 100, 50,  4, 0, 1, 1, 0, 6, 2, 0, 0, 100, 50));
        tbl.push_back(mk("goal_l0",        1, 0, 0, 0, 1, 0, 100, 50,  2, 1, 2, 0, 0, 6, 2, 0, 0, 100, 50));
        tbl.push_back(mk("play_l1",        1, 0, 0, 0, 0, 0, 100, 50,  4, 1, 2, 1, 0, 6, 2, 0, 0, 100, 50));
        tbl.push_back(mk("goal_l1",        1, 0, 0, 0, 1, 0, 100, 50,  2, 2, 4, 0, 0, 6, 2, 0, 0, 100, 50));
        tbl.push_back(mk("play_l2",        1, 0, 0, 0, 0, 0, 100, 50,  4, 2, 4, 1, 0, 6, 2, 0, 0, 100, 50));
        tbl.push_back(mk("goal_l2",        1, 0, 0, 0, 1, 0, 100, 50,  2, 3, 8, 0, 0, 6, 2, 0, 0, 100, 50));
        tbl.push_back(mk("play_l3",        1, 0, 0, 0, 0, 0, 100, 50,  4, 3, 8, 1, 0, 6, 2, 0, 0, 100, 50));
        tbl.push_back(mk("win",            1, 0, 0, 0, 1, 0, 100, 50,  2, 3, 0, 0, 0, 6, 2, 0, 1, 100, 50));
        tbl.push_back(mk("win_to_idle",    1, 1, 0, 0, 0, 0, 100, 50,  1, 3, 0, 0, 0, 6, 2, 0, 0, 100, 50));
        tbl.push_back(mk("restart",        1, 1, 0, 0, 0, 0, 100, 50,  1, 0, 1, 0, 0, 6, 3, 0, 0, 100, 50));
        tbl.push_back(mk("play_b",         1, 0, 0, 0, 0, 0, 100, 50,  4, 0, 1, 1, 0, 6, 3, 0, 0, 100, 50));
        tbl.push_back(mk("death1",         1, 0, 0, 1, 0, 0, 100, 50,  1, 0, 1, 1, 0, 6, 2, 0, 0, 100, 50));
        tbl.push_back(mk("respawn1",       1, 0, 0, 0, 0, 1, 100, 50,  60, 0, 1, 0, 0, 6, 2, 0, 0, 100, 50));
        tbl.push_back(mk("play_c",         1, 0, 0, 0, 0, 0, 100, 50,  4, 0, 1, 1, 0, 6, 2, 0, 0, 100, 50));
        tbl.push_back(mk("death2",         1, 0, 0, 1, 0, 0, 100, 50,  1, 0, 1, 1, 0, 6, 1, 0, 0, 100, 50));
        tbl.push_back(mk("respawn2",       1, 0, 0, 0, 0, 1, 100, 50,  60, 0, 1, 0, 0, 6, 1, 0, 0, 100, 50));
        tbl.push_back(mk("play_d",         1, 0, 0, 0, 0, 0, 100, 50,  4, 0, 1, 1, 0, 6, 1, 0, 0, 100, 50));
        tbl.push_back(mk("death3",         1, 0, 0, 1, 0, 0, 100, 50,  1, 0, 1, 1, 0, 6, 0, 0, 0, 100, 50));
        tbl.push_back(mk("game_over",      1, 0, 0, 0, 0, 1, 100, 50,  60, 0, 0, 0, 0, 6, 0, 1, 0, 100, 50));
        tbl.push_back(mk("over_to_idle",   1, 1, 0, 0, 0, 0, 100, 50,  1, 0, 0, 0, 0, 6, 0, 0, 0, 100, 50));
        tbl.push_back(mk("new_game",       1, 1, 0, 0, 0, 0, 100, 50,  1, 0, 1, 0, 0, 6, 3, 0, 0, 100, 50));
        tbl.push_back(mk("play_e",         1, 0, 0, 0, 0, 0, 320, 200, 4, 0, 1, 1, 0, 6, 3, 0, 0, 100, 50));
        tbl.push_back(mk("drop3",          1, 0, 1, 0, 0, 1, 320, 200, 1, 0, 1, 1, 1, 5, 3, 0, 0, 320, 200));
        tbl.push_back(mk("reset_mid_bomb", 0, 0, 0, 0, 0, 1, 320, 200, 1, 0, 0, 0, 0, 0, 3, 0, 0, 0,   0));

        foreach (tbl[i]) begin
            rst_n = tbl[i].r; start_key = tbl[i].st; f_key = tbl[i].f; death_in = tbl[i].d;
            goal_in = tbl[i].g; frame_tick = tbl[i].t;
            char_pos_x = 10'(tbl[i].cx); char_pos_y = 10'(tbl[i].cy);
            repeat (tbl[i].n) cyc();
            check(tbl[i].name, dut_out(), vec_exp(tbl[i]));
        end

        // Random play against the behavioural model, one comparison per clock.
        for (int k = 0; k < 20000 && failures < 10; k++) begin
            rst_n      = ($urandom_range(0, 2999) != 0);
            start_key  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) f_key = ~f_key;
            death_in   = ($urandom_range(0, 799) == 0);
            goal_in    = ($urandom_range(0, 999) == 0);
            frame_tick = ($urandom_range(0, 3) != 0);
            char_pos_x = 10'($urandom_range(0, 634));
            char_pos_y = 10'($urandom_range(0, 474));
            cyc();
            check("random_vs_model", dut_out(), model_out());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
